// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the memory-game control unit: state codes,
// LED source selector codes and the bundle of datapath strobes.
package unidade_controle_pkg;

  // State codes double as the db_estado debug value, so they are fixed.
  typedef enum logic [3:0] {
    INICIAL           = 4'h0,
    PREPARACAO        = 4'h1,
    MOSTRA_LED        = 4'h2,
    ZERA_TEMPO        = 4'h3,
    APAGA_LED         = 4'h4,
    PROXIMO_LED       = 4'h5,
    PREPARA_JOGADA    = 4'h6,
    ESPERA_JOGADA     = 4'h7,
    REGISTRA          = 4'h8,
    COMPARACAO        = 4'h9,
    PROXIMA_JOGADA    = 4'hA,
    PROXIMA_SEQUENCIA = 4'hB,
    FIM_ACERTOU       = 4'hC,
    FIM_ERROU         = 4'hD,
    FIM_TIMEOUT       = 4'hE
  } estado_t;

  // LED source: dark, ROM contents, or the player's registered buttons.
  localparam logic [1:0] SEL_APAGADO = 2'b00;
  localparam logic [1:0] SEL_MEMORIA = 2'b01;
  localparam logic [1:0] SEL_JOGADA  = 2'b10;

  // Every strobe and result flag the controller drives, decoded together.
  typedef struct packed {
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       zeraM;
    logic       contaM;
    logic       registraR;
    logic       contaT;
    logic [1:0] seletor;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       db_timeout;
  } ctrl_t;

  localparam ctrl_t CTRL_NENHUM = '0;

endpackage

// File: rtl/unidade_controle_if.sv
// Control/status bundle between the game controller and its datapath.
// master: the controller (reads status, drives strobes).
// slave: the datapath side (drives status, reads strobes).
interface unidade_controle_if;

  logic       iniciar;
  logic       fimL;
  logic       fimM;
  logic       endecoIgualLimite;
  logic       jogada_feita;
  logic       botoesIgualMemoria;
  logic       timeout;

  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       zeraM;
  logic       contaM;
  logic       registraR;
  logic       contaT;
  logic [1:0] seletor;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, fimL, fimM, endecoIgualLimite, jogada_feita,
           botoesIgualMemoria, timeout,
    output zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR,
           contaT, seletor, pronto, acertou, errou, db_timeout, db_estado
  );

  modport slave (
    output iniciar, fimL, fimM, endecoIgualLimite, jogada_feita,
           botoesIgualMemoria, timeout,
    input  zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR,
           contaT, seletor, pronto, acertou, errou, db_timeout, db_estado
  );

endinterface

// File: rtl/unidade_controle.sv
// Moore controller for the memory game: shows the LED sequence up to the
// current limit, collects and checks each player move under a per-move
// timeout, grows the sequence and reports win, loss or timeout.
module unidade_controle
  import unidade_controle_pkg::*;
(
  input logic               clock,
  input logic               reset,
  unidade_controle_if.master bus
);

  estado_t estado_q;
  estado_t estado_d;
  ctrl_t   ctrl;

  // State register; reset drops the game back to idle at any moment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  // Next-state rules of the game sequence.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:           if (bus.iniciar) estado_d = PREPARACAO;
      PREPARACAO:        estado_d = MOSTRA_LED;
      MOSTRA_LED:        if (bus.fimM) estado_d = ZERA_TEMPO;
      ZERA_TEMPO:        estado_d = APAGA_LED;
      APAGA_LED:         if (bus.fimM) estado_d = PROXIMO_LED;
      PROXIMO_LED:       estado_d = bus.endecoIgualLimite ? PREPARA_JOGADA
                                                          : MOSTRA_LED;
      PREPARA_JOGADA:    estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (bus.jogada_feita) estado_d = REGISTRA;
        else if (bus.timeout) estado_d = FIM_TIMEOUT;
      end
      REGISTRA:          estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!bus.botoesIgualMemoria)
          estado_d = FIM_ERROU;
        else if (bus.endecoIgualLimite && bus.fimL)
          estado_d = FIM_ACERTOU;
        else if (bus.endecoIgualLimite)
          estado_d = PROXIMA_SEQUENCIA;
        else
          estado_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA:    estado_d = ESPERA_JOGADA;
      PROXIMA_SEQUENCIA: estado_d = MOSTRA_LED;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:       if (bus.iniciar) estado_d = PREPARACAO;
      default:           estado_d = INICIAL;
    endcase
  end

  // Output decode from state; contaE in proximo_led is the only term that
  // also looks at a (state-stable) datapath flag.
  always_comb begin
    ctrl = CTRL_NENHUM;
    case (estado_q)
      PREPARACAO: begin
        ctrl.zeraE = 1'b1;
        ctrl.zeraL = 1'b1;
        ctrl.zeraR = 1'b1;
        ctrl.zeraM = 1'b1;
      end
      MOSTRA_LED: begin
        ctrl.seletor = SEL_MEMORIA;
        ctrl.contaM  = 1'b1;
      end
      ZERA_TEMPO: begin
        ctrl.seletor = SEL_APAGADO;
        ctrl.zeraM   = 1'b1;
      end
      APAGA_LED: begin
        ctrl.seletor = SEL_APAGADO;
        ctrl.contaM  = 1'b1;
      end
      PROXIMO_LED: begin
        ctrl.zeraM  = 1'b1;
        ctrl.contaE = !bus.endecoIgualLimite;
      end
      PREPARA_JOGADA: begin
        ctrl.zeraE = 1'b1;
        ctrl.zeraR = 1'b1;
      end
      ESPERA_JOGADA:     ctrl.contaT = 1'b1;
      REGISTRA: begin
        ctrl.registraR = 1'b1;
        ctrl.seletor   = SEL_JOGADA;
      end
      COMPARACAO:        ctrl.seletor = SEL_JOGADA;
      PROXIMA_JOGADA:    ctrl.contaE = 1'b1;
      PROXIMA_SEQUENCIA: begin
        ctrl.contaL = 1'b1;
        ctrl.zeraE  = 1'b1;
        ctrl.zeraM  = 1'b1;
        ctrl.zeraR  = 1'b1;
      end
      FIM_ACERTOU: begin
        ctrl.pronto  = 1'b1;
        ctrl.acertou = 1'b1;
      end
      FIM_ERROU: begin
        ctrl.pronto = 1'b1;
        ctrl.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        ctrl.pronto     = 1'b1;
        ctrl.errou      = 1'b1;
        ctrl.db_timeout = 1'b1;
      end
      default:           ctrl = CTRL_NENHUM;
    endcase
  end

  assign bus.zeraE      = ctrl.zeraE;
  assign bus.contaE     = ctrl.contaE;
  assign bus.zeraL      = ctrl.zeraL;
  assign bus.contaL     = ctrl.contaL;
  assign bus.zeraR      = ctrl.zeraR;
  assign bus.zeraM      = ctrl.zeraM;
  assign bus.contaM     = ctrl.contaM;
  assign bus.registraR  = ctrl.registraR;
  assign bus.contaT     = ctrl.contaT;
  assign bus.seletor    = ctrl.seletor;
  assign bus.pronto     = ctrl.pronto;
  assign bus.acertou    = ctrl.acertou;
  assign bus.errou      = ctrl.errou;
  assign bus.db_timeout = ctrl.db_timeout;
  assign bus.db_estado  = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for the memory-game controller: plays whole games at the level of
// rounds, LEDs and moves, with random display/wait durations and random
// player behaviour, and checks the state code and every output each cycle.
module tb_unidade_controle;

  localparam logic [3:0] S_INICIAL    = 4'h0;
  localparam logic [3:0] S_PREPARACAO = 4'h1;
  localparam logic [3:0] S_MOSTRA     = 4'h2;
  localparam logic [3:0] S_ZERA_TEMPO = 4'h3;
  localparam logic [3:0] S_APAGA      = 4'h4;
  localparam logic [3:0] S_PROX_LED   = 4'h5;
  localparam logic [3:0] S_PREP_JOG   = 4'h6;
  localparam logic [3:0] S_ESPERA     = 4'h7;
  localparam logic [3:0] S_REGISTRA   = 4'h8;
  localparam logic [3:0] S_COMPARA    = 4'h9;
  localparam logic [3:0] S_PROX_JOG   = 4'hA;
  localparam logic [3:0] S_PROX_SEQ   = 4'hB;
  localparam logic [3:0] S_ACERTOU    = 4'hC;
  localparam logic [3:0] S_ERROU      = 4'hD;
  localparam logic [3:0] S_TIMEOUT    = 4'hE;

  localparam int MOVE_OK      = 0;
  localparam int MOVE_WRONG   = 1;
  localparam int MOVE_TIMEOUT = 2;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  unidade_controle_if bus();

  unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [14:0] observed;
  assign observed = {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR,
                     bus.zeraM, bus.contaM, bus.registraR, bus.contaT,
                     bus.seletor, bus.pronto, bus.acertou, bus.errou,
                     bus.db_timeout};

  // Output table of each state, written straight from the state/output list.
  function automatic logic [14:0] expected_outputs(input logic [3:0] st,
                                                   input logic endeco);
    logic ze, ce, zl, cl, zr, zm, cm, rr, ct, pr, ac, er, dt;
    logic [1:0] sel;
    ze = 0; ce = 0; zl = 0; cl = 0; zr = 0; zm = 0; cm = 0;
    rr = 0; ct = 0; pr = 0; ac = 0; er = 0; dt = 0; sel = 2'b00;
    case (st)
      S_PREPARACAO: begin ze = 1; zl = 1; zr = 1; zm = 1; end
      S_MOSTRA:     begin sel = 2'b01; cm = 1; end
      S_ZERA_TEMPO: begin zm = 1; end
      S_APAGA:      begin cm = 1; end
      S_PROX_LED:   begin zm = 1; ce = !endeco; end
      S_PREP_JOG:   begin ze = 1; zr = 1; end
      S_ESPERA:     begin ct = 1; end
      S_REGISTRA:   begin rr = 1; sel = 2'b10; end
      S_COMPARA:    begin sel = 2'b10; end
      S_PROX_JOG:   begin ce = 1; end
      S_PROX_SEQ:   begin cl = 1; ze = 1; zm = 1; zr = 1; end
      S_ACERTOU:    begin pr = 1; ac = 1; end
      S_ERROU:      begin pr = 1; er = 1; end
      S_TIMEOUT:    begin pr = 1; er = 1; dt = 1; end
      default:      ;
    endcase
    return {ze, ce, zl, cl, zr, zm, cm, rr, ct, sel, pr, ac, er, dt};
  endfunction

  // Drive one cycle of inputs, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic ini, input logic fm,
                               input logic en, input logic jf,
                               input logic bm, input logic to,
                               input logic fl);
    bus.iniciar            = ini;
    bus.fimM               = fm;
    bus.endecoIgualLimite  = en;
    bus.jogada_feita       = jf;
    bus.botoesIgualMemoria = bm;
    bus.timeout            = to;
    bus.fimL               = fl;
    @(posedge clock);
    #1;
  endtask

  // Compare state code and the full output vector against expectations.
  task automatic checkOutput(input string tag, input logic [3:0] exp_state);
    logic [14:0] exp_out;
    exp_out = expected_outputs(exp_state, bus.endecoIgualLimite);
    vectors++;
    assert (bus.db_estado === exp_state) else begin
      miscompares++;
      $error("FAIL %s db_estado observed=%0h expected=%0h",
             tag, bus.db_estado, exp_state);
    end
    vectors++;
    assert (observed === exp_out) else begin
      miscompares++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, observed, exp_out);
    end
  endtask

  // Show one LED: random-length on phase, dark phase, then advance.
  task automatic show_led(input logic last);
    int d_on, d_off;
    d_on  = int'($urandom_range(0, 3));
    d_off = int'($urandom_range(0, 3));
    for (int w = 0; w < d_on; w++) begin
      applyStimulus(0, 0, last, 0, 0, 0, 0);
      checkOutput("mostra_led_hold", S_MOSTRA);
    end
    applyStimulus(0, 1, last, 0, 0, 0, 0);
    checkOutput("zera_tempo", S_ZERA_TEMPO);
    applyStimulus(0, 0, last, 0, 0, 0, 0);
    checkOutput("apaga_led", S_APAGA);
    for (int w = 0; w < d_off; w++) begin
      applyStimulus(0, 0, last, 0, 0, 0, 0);
      checkOutput("apaga_led_hold", S_APAGA);
    end
    applyStimulus(0, 1, last, 0, 0, 0, 0);
    checkOutput("proximo_led", S_PROX_LED);
    applyStimulus(0, 0, last, 0, 0, 0, 0);
    checkOutput("after_proximo_led", last ? S_PREP_JOG : S_MOSTRA);
  endtask

  // One player move starting from the wait state.
  task automatic play_move(input logic last, input logic final_round,
                           input int outcome);
    int   espera;
    logic fl;
    espera = int'($urandom_range(0, 3));
    for (int w = 0; w < espera; w++) begin
      applyStimulus(0, 0, last, 0, 0, 0, 0);
      checkOutput("espera_jogada_hold", S_ESPERA);
    end
    if (outcome == MOVE_TIMEOUT) begin
      applyStimulus(0, 0, last, 0, 0, 1, 0);
      checkOutput("fim_timeout", S_TIMEOUT);
      return;
    end
    applyStimulus(0, 0, last, 1, 0, 1'($urandom_range(0, 1)), 0);
    checkOutput("registra", S_REGISTRA);
    applyStimulus(0, 0, last, 0, 0, 0, 0);
    checkOutput("comparacao", S_COMPARA);
    fl = final_round | (!last & 1'($urandom_range(0, 1)));
    applyStimulus(0, 0, last, 0, outcome == MOVE_OK, 0, fl);
    if (outcome == MOVE_WRONG) begin
      checkOutput("fim_errou", S_ERROU);
    end else if (!last) begin
      checkOutput("proxima_jogada", S_PROX_JOG);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("back_to_espera", S_ESPERA);
    end else if (final_round) begin
      checkOutput("fim_acertou", S_ACERTOU);
    end else begin
      checkOutput("proxima_sequencia", S_PROX_SEQ);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("next_round_mostra", S_MOSTRA);
    end
  endtask

  // Round k: show k+1 LEDs, then collect k+1 moves (one may be bad).
  task automatic play_round(input int k, input int wrong_at,
                            input int timeout_at);
    int oc;
    for (int i = 0; i <= k; i++) show_led(i == k);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("espera_jogada", S_ESPERA);
    for (int j = 0; j <= k; j++) begin
      oc = (j == wrong_at) ? MOVE_WRONG :
           (j == timeout_at) ? MOVE_TIMEOUT : MOVE_OK;
      play_move(j == k, k == 15, oc);
      if (oc != MOVE_OK) return;
    end
  endtask

  // Press start from an idle or end state and land in the first show.
  task automatic start_game();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("preparacao", S_PREPARACAO);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("first_mostra", S_MOSTRA);
  endtask

  // Stay in an end state for a few cycles without a start request.
  task automatic hold_result(input logic [3:0] st);
    for (int w = 0; w < 3; w++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("result_hold", st);
    end
  endtask

  initial begin
    int bad_round;
    reset = 1'b1;
    bus.iniciar = 0; bus.fimM = 0; bus.endecoIgualLimite = 0;
    bus.jogada_feita = 0; bus.botoesIgualMemoria = 0; bus.timeout = 0;
    bus.fimL = 0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", S_INICIAL);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_no_start", S_INICIAL);

    // Full winning game: 16 rounds.
    start_game();
    for (int k = 0; k < 16; k++) play_round(k, -1, -1);
    hold_result(S_ACERTOU);
    start_game();

    // Game lost by a wrong move somewhere in a random round.
    bad_round = int'($urandom_range(1, 4));
    for (int k = 0; k < bad_round; k++) play_round(k, -1, -1);
    play_round(bad_round, int'($urandom_range(0, bad_round)), -1);
    hold_result(S_ERROU);
    start_game();

    // Game lost by timeout on the first move.
    play_round(0, -1, 0);
    hold_result(S_TIMEOUT);
    start_game();

    // Move and timeout in the same cycle: the move wins.
    show_led(1'b1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("espera_jogada", S_ESPERA);
    applyStimulus(0, 0, 1, 1, 0, 1, 0);
    checkOutput("move_beats_timeout", S_REGISTRA);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("comparacao", S_COMPARA);
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    checkOutput("proxima_sequencia", S_PROX_SEQ);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("next_round_mostra", S_MOSTRA);

    // Asynchronous reset while the LED is dark.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("zera_tempo", S_ZERA_TEMPO);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("apaga_led", S_APAGA);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_async", S_INICIAL);
    @(posedge clock);
    #1;
    checkOutput("reset_held", S_INICIAL);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_after_reset", S_INICIAL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore FSM that drives the memory-game datapath one stage upstream of it.
- Consumes the datapath status flags and produces every datapath control strobe.
- Sequences the game: show the LED sequence up to the current limit, collect and compare player moves with a per-move timeout, grow the sequence, and report win/loss/timeout.

Parameters:
- none (all timing comes from datapath counters)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state inicial
- iniciar  input  1  start request, level-sampled
- fimL  input  1  limit counter at last position (15)
- fimM  input  1  display timer terminal count
- endecoIgualLimite  input  1  address == current limit
- jogada_feita  input  1  one-cycle pulse on a new button press
- botoesIgualMemoria  input  1  registered buttons == ROM data
- timeout  input  1  move timer expired
- zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR, contaT  output  1 each  datapath strobes
- seletor  output  2  LED source: 00 off, 01 ROM data, 10 registered buttons
- pronto, acertou, errou, db_timeout  output  1 each  game result
- db_estado  output  4  current state code

Behaviour:
- Clock, reset and output style:
  - Single clock domain.
  - reset asserted at any time, including mid-game, puts the FSM in inicial asynchronously.
  - All outputs are decoded combinationally from state only (Moore); no input-to-output paths.
- Reset / inicial values: every strobe 0, seletor 00, pronto/acertou/errou/db_timeout 0, db_estado 0000.
- State codes and their asserted outputs (any output not listed is 0):
  - 0 inicial: none.
  - 1 preparacao: zeraE, zeraL, zeraR, zeraM.
  - 2 mostra_led: seletor 01, contaM.
  - 3 zera_tempo: seletor 00, zeraM.
  - 4 apaga_led: seletor 00, contaM.
  - 5 proximo_led: zeraM; contaE only when !endecoIgualLimite. This is the single Mealy-gated exception; the condition is a state-stable datapath flag.
  - 6 prepara_jogada: zeraE, zeraR.
  - 7 espera_jogada: contaT.
  - 8 registra: registraR, seletor 10.
  - 9 comparacao: seletor 10.
  - A proxima_jogada: contaE.
  - B proxima_sequencia: contaL, zeraE, zeraM, zeraR.
  - C fim_acertou: pronto, acertou.
  - D fim_errou: pronto, errou.
  - E fim_timeout: pronto, errou, db_timeout.
- Transitions:
  - inicial: iniciar -> preparacao, else stay.
  - preparacao -> mostra_led (unconditional).
  - mostra_led: fimM -> zera_tempo, else stay.
  - zera_tempo -> apaga_led.
  - apaga_led: fimM -> proximo_led, else stay.
  - proximo_led: endecoIgualLimite -> prepara_jogada, else -> mostra_led.
  - prepara_jogada -> espera_jogada.
  - espera_jogada:
    - jogada_feita -> registra.
    - else timeout -> fim_timeout.
    - else stay.
    - If both arrive in the same cycle, jogada_feita wins.
  - registra -> comparacao. The comparison is evaluated one cycle after the register load.
  - comparacao:
    - !botoesIgualMemoria -> fim_errou.
    - else endecoIgualLimite & fimL -> fim_acertou.
    - else endecoIgualLimite -> proxima_sequencia.
    - else -> proxima_jogada.
  - proxima_jogada -> espera_jogada.
  - proxima_sequencia -> mostra_led.
  - fim_acertou, fim_errou, fim_timeout: iniciar -> preparacao, else hold. Results stay asserted while holding.
  - Code F (illegal) -> inicial on the next clock, with all outputs 0.
- Timing rules:
  - contaT is high only in espera_jogada. Each departure clears the move timer, so the timeout applies per move.
  - A full 16-entry win takes 16 show rounds. Round k (limit k, k = 0..15) shows k+1 LEDs and collects k+1 moves.

Decomposition:
- Shared constants include file (unidade_controle_estados): the 4-bit state codes listed above and the seletor codes (SEL_APAGADO=00, SEL_MEMORIA=01, SEL_JOGADA=10).
- One module, with next-state and output decode as separate always blocks.
- No sub-module is natural.

Test Plan:
- Reset then iniciar=1 for one cycle -> db_estado 0->1->2; preparacao asserts zeraE=zeraL=zeraR=zeraM=1 for exactly 1 cycle.
- Round 0: fimM pulses in mostra_led and apaga_led, endecoIgualLimite=1 -> states 2,3,4,5,6,7, with seletor 01 in 2 and 00 in 4; then jogada_feita with botoesIgualMemoria=1, fimL=0 -> 8,9,B (contaL=1), back to 2.
- Wrong move: in 7, jogada_feita=1, then botoesIgualMemoria=0 in 9 -> state D, pronto=1, errou=1, acertou=0; held until iniciar, then state 1.
- Timeout: hold state 7 with timeout=1 and jogada_feita=0 -> state E, db_timeout=1, errou=1; same cycle jogada_feita=1 and timeout=1 -> state 8 instead.
- Final win: in 9 with botoesIgualMemoria=1, endecoIgualLimite=1, fimL=1 -> state C, acertou=1, pronto=1; mid-round (endecoIgualLimite=0) -> state A with contaE=1 for 1 cycle, then 7.
- Assert reset while in state 4 -> db_estado=0 immediately (before the next edge), all strobes 0.
